alu_op_sequencer: RTL

Sequential initiator for the team's combinational arithmetic unit. It accepts operand/opcode commands over a valid/ready stream and buffers them in a small FIFO. Each command drives the arithmetic unit's A/B/operation inputs from registers, waits a fixed settle time, then samples result and flags into a valid/ready response stream. It screens illegal opcodes and zero divisors, and computes the Z flag locally.

---
 rtl/alu_op_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, drives a combinational arithmetic unit from registers, returns one response per command.
// Latency: pop 1 cycle after accept, response SETTLE cycles after pop (rejects respond at pop); rsp_ready stall fills FIFO then drops cmd_ready.

// Generic synchronous FIFO, registered count, no same-cycle pass-through.
module alu_op_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module alu_op_sequencer #(
  parameter int NBIT       = 8,
  parameter int SETTLE     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [NBIT-1:0] cmd_a,
  input  logic [NBIT-1:0] cmd_b,
  input  logic [2:0]      cmd_op,
  output logic [NBIT-1:0] alu_a,
  output logic [NBIT-1:0] alu_b,
  output logic [2:0]      alu_op,
  input  logic [NBIT-1:0] alu_result,
  input  logic            alu_n,
  input  logic            alu_c,
  input  logic            alu_v,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [NBIT-1:0] rsp_result,
  output logic            rsp_n,
  output logic            rsp_z,
  output logic            rsp_c,
  output logic            rsp_v,
  output logic            rsp_err,
  output logic            busy
);
  typedef struct packed {
    logic [NBIT-1:0] a;
    logic [NBIT-1:0] b;
    logic [2:0]      op;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

  cmd_t       push_cmd;
  cmd_t       head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       head_reject;
  state_t     state;
  logic [3:0] settle_cnt;

  assign push_cmd.a  = cmd_a;
  assign push_cmd.b  = cmd_b;
  assign push_cmd.op = cmd_op;

  alu_op_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (cmd_valid),
    .push_dat (push_cmd),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign busy      = (state != IDLE) || !fifo_empty;

  // Undefined opcodes and zero divisors never reach the arithmetic unit.
  always_comb begin
    head_reject = 1'b0;
    case (head.op)
      3'b000, 3'b001, 3'b010: head_reject = 1'b0;
      3'b011, 3'b101:         head_reject = (head.b == '0);
      default:                head_reject = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_n      <= 1'b0;
      rsp_z      <= 1'b0;
      rsp_c      <= 1'b0;
      rsp_v      <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            if (head_reject) begin
              rsp_result <= '0;
              rsp_n      <= 1'b0;
              rsp_z      <= 1'b0;
              rsp_c      <= 1'b0;
              rsp_v      <= 1'b0;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              alu_a      <= head.a;
              alu_b      <= head.b;
              alu_op     <= head.op;
              settle_cnt <= SETTLE_INIT;
              state      <= WAIT;
            end
          end
        end
        WAIT: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_n      <= alu_n;
            rsp_z      <= (alu_result == '0);
            rsp_c      <= alu_c;
            rsp_v      <= alu_v;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
